stream_mux_rr: RTL and testbench
================================

# stream_mux_rr

Parametrised N-channel, W-bit streaming multiplexer with a registered output and valid/ready handshakes on every port. It supersedes the combinational 4:1 select mux. A run-time mode picks either a fixed channel (sel-driven) or fair round-robin arbitration across valid channels. It sits between multiple producer streams and a single consumer, for example a shared UART/display sink.

## Interface
Parameters:
- `NCH`, 4 — number of input channels, at least 2.
- `W`, 8 — data width per channel, at least 1.
- `SW`, `$clog2(NCH)` — select/grant width (derived; do not override).

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst_n`  in  1  — reset; synchronous, active-low.
- `mode`  in  1  — 0 = fixed select by `sel`; 1 = round-robin.
- `sel`  in  SW  — channel index used when `mode`=0; values ≥ NCH select nothing.
- `in_data`  in  NCH*W  — channel k occupies bits [k*W +: W].
- `in_valid`  in  NCH  — per-channel valid.
- `in_ready`  out  NCH  — per-channel ready; at most one bit high (one-hot or zero).
- `out_data`  out  W  — registered output beat.
- `out_sel`  out  SW  — channel index of the beat currently in `out_data`.
- `out_valid`  out  1  — output register holds a beat.
- `out_ready`  in  1  — consumer accepts the beat.

## Operation
- A one-entry output register is held by `out_data`, `out_sel` and `out_valid`.
- `load = !out_valid || out_ready`. This allows a full-throughput pass: drain and refill in the same cycle.
- Candidate channel, `cand`:
  - `mode`=0: `cand = sel` if `sel < NCH` and `in_valid[sel]`; otherwise there is no candidate.
  - `mode`=1: the first k with `in_valid[k]`=1, searching from `last+1` upward and wrapping NCH-1→0.
- `in_ready[k] = load && candidate_exists && (k == cand)`. This is combinational from `out_ready`, `in_valid`, `mode` and `sel`.
- Transfer on channel k when `in_valid[k] && in_ready[k]`. On the next edge: `out_data` ← channel k data, `out_sel` ← k, `out_valid` ← 1.
- If `load` is true but there is no candidate, `out_valid` ← 0 and `out_data`/`out_sel` hold their values.
- `last` (internal, SW bits) is updated to k on every transfer in `mode`=1 only. It is unchanged in `mode`=0.
- A `mode` or `sel` change takes effect on the next arbitration; a beat already in the output register is unaffected.
- While `out_valid`=1 and `out_ready`=0, all `in_ready` are 0 and the output is stable.

## Timing
- Latency is 1 cycle from the input transfer edge to `out_valid`.
- Throughput is 1 beat/cycle with `out_ready` held high.
- Round-robin fairness: with all NCH channels continuously valid, grants follow 0,1,…,NCH-1,0,… with no channel starved for more than NCH-1 beats.
- Reset (`rst_n`=0 sampled at an edge):
  - Outputs: `out_valid`=0, `out_data`=0, `out_sel`=0.
  - Internal state: `last`=NCH-1, so channel 0 has first priority.
  - `in_ready` is forced to 0 while `rst_n`=0.
  - Reset mid-transfer drops the held beat; no partial state survives.

## Configuration
- Macro: `STREAM_MUX_PKT_LOCK_EN`.
- Defined:
  - Adds port `in_last` (in, NCH) and port `out_last` (out, 1; reset 0). `out_last` is registered alongside `out_data`.
  - After a transfer from channel k with `in_last[k]`=0, the grant is locked to k. `cand = k` regardless of `mode`, `sel` or other valids, until a beat with `in_last[k]`=1 transfers.
  - Reset clears the lock.
- Undefined: no `in_last`/`out_last` ports; every beat is arbitrated independently.

## Test plan
- Reset check: hold `rst_n`=0 with all `in_valid`=1 → `in_ready`=0, `out_valid`=0, `out_data`=0. After release with `mode`=1, the first granted channel is 0.
- Fixed mode: `mode`=0, `sel`=2, channel 2 data 0xA5, all valid, `out_ready`=1 → only `in_ready[2]`=1; next cycle `out_data`=0xA5, `out_sel`=2.
- Round-robin fairness: `mode`=1, NCH=4, all valid for 8 cycles, `out_ready`=1 → `out_sel` sequence 0,1,2,3,0,1,2,3 on back-to-back cycles. Then only channels 1 and 3 valid → alternates 1,3,1,3.
- Backpressure: drop `out_ready` for 3 cycles while `out_valid`=1 → `out_data`/`out_sel` stable and `in_ready`=0. Reassert → the held beat drains and the next beat loads the same cycle, with no loss or duplication (scoreboard by channel).
- Edge inputs: `mode`=0, `sel`=NCH (for NCH not a power of two) or `sel` on an invalid channel → no `in_ready`; after drain, `out_valid`=0.
- With `STREAM_MUX_PKT_LOCK_EN`: `mode`=1, channel 1 sends a 3-beat packet (`in_last` on beat 3) while channel 0 and channel 2 are valid → `out_sel`=1,1,1, then 2. Asserting `rst_n`=0 after beat 2 clears the lock, and channel 0 is granted first after release.

Source files
------------

// File: rtl/stream_mux_rr.sv
// N-channel registered stream mux with fixed-select or round-robin arbitration.
// Optional packet lock (grant held until in_last) under STREAM_MUX_PKT_LOCK_EN.

module stream_mux_rr_lane #(
  parameter int SW  = 2,
  parameter int IDX = 0
) (
  input  logic          rst_n,
  input  logic          load,
  input  logic          cand_vld,
  input  logic [SW-1:0] cand,
  input  logic          valid,
  output logic          ready,
  output logic          take
);
  assign ready = rst_n && load && cand_vld && (cand == SW'(IDX));
  assign take  = valid && ready;
endmodule

module stream_mux_rr #(
  parameter int NCH = 4,
  parameter int W   = 8,
  parameter int SW  = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [SW-1:0]     sel,
  input  logic [NCH*W-1:0]  in_data,
  input  logic [NCH-1:0]    in_valid,
`ifdef STREAM_MUX_PKT_LOCK_EN
  input  logic [NCH-1:0]    in_last,
  output logic              out_last,
`endif
  output logic [NCH-1:0]    in_ready,
  output logic [W-1:0]      out_data,
  output logic [SW-1:0]     out_sel,
  output logic              out_valid,
  input  logic              out_ready
);

  logic          load;
  logic          cand_vld;
  logic [SW-1:0] cand;
  logic [SW-1:0] last;
  logic [NCH-1:0] take;
  logic          xfer;
  logic          lock_vld;
  logic [SW-1:0] lock_ch;

  assign load = !out_valid || out_ready;
  assign xfer = |take;

  // Candidate selection; the downward RR loop leaves the nearest valid channel after last.
  always_comb begin
    cand_vld = 1'b0;
    cand     = '0;
    if (lock_vld) begin
      cand     = lock_ch;
      cand_vld = in_valid[lock_ch];
    end else if (!mode) begin
      if (int'(sel) < NCH) begin
        cand     = sel;
        cand_vld = in_valid[sel];
      end
    end else begin
      for (int i = NCH; i >= 1; i--) begin
        if (in_valid[(int'(last) + i) % NCH]) begin
          cand     = SW'((int'(last) + i) % NCH);
          cand_vld = 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    stream_mux_rr_lane #(.SW(SW), .IDX(k)) u_lane (
      .rst_n    (rst_n),
      .load     (load),
      .cand_vld (cand_vld),
      .cand     (cand),
      .valid    (in_valid[k]),
      .ready    (in_ready[k]),
      .take     (take[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
      last      <= SW'(NCH - 1);
    end else if (load) begin
      if (xfer) begin
        out_data  <= in_data[cand*W +: W];
        out_sel   <= cand;
        out_valid <= 1'b1;
        if (mode) last <= cand;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef STREAM_MUX_PKT_LOCK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_last <= 1'b0;
      lock_vld <= 1'b0;
      lock_ch  <= '0;
    end else if (xfer) begin
      out_last <= in_last[cand];
      lock_vld <= !in_last[cand];
      lock_ch  <= cand;
    end
  end
`else
  assign lock_vld = 1'b0;
  assign lock_ch  = '0;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed self-checking bench for stream_mux_rr (NCH=4, W=8); lock tests under STREAM_MUX_PKT_LOCK_EN.

module tb_stream_mux_rr;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;
`ifdef STREAM_MUX_PKT_LOCK_EN
  logic [3:0]  in_last;
  logic        out_last;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.NCH(4), .W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
`ifdef STREAM_MUX_PKT_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] s, input logic [7:0] d);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sel"},   32'(out_sel),   32'(s));
    chk({tag, "_data"},  32'(out_data),  32'(d));
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b1; sel = 2'd0; in_valid = 4'hF; out_ready = 1'b1;
    in_data = 32'h44332211;
`ifdef STREAM_MUX_PKT_LOCK_EN
    in_last = 4'hF;
`endif
    cyc(); cyc();
    chk("rst_ready", 32'(in_ready), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data",  32'(out_data), 32'h0);
    chk("rst_sel",   32'(out_sel), 32'h0);

    // Release: channel 0 has first priority
    rst_n = 1'b1; #1;
    chk("rel_ready", 32'(in_ready), 32'b0001);
    cyc();
    chk_out("rel", 2'd0, 8'h11);

    // Fixed select
    mode = 1'b0; sel = 2'd2; in_data = 32'h44A52211; #1;
    chk("fix_ready", 32'(in_ready), 32'b0100);
    cyc();
    chk_out("fix", 2'd2, 8'hA5);

    // Round robin, all valid, from fresh reset
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    mode = 1'b1; in_data = 32'h13121110; in_valid = 4'hF; #1;
    for (int i = 0; i < 8; i++) begin
      chk("rr_ready", 32'(in_ready), 32'(4'b0001 << (i % 4)));
      cyc();
      chk_out("rr", 2'(i % 4), 8'h10 + 8'(i % 4));
    end

    // Only channels 1 and 3 valid
    in_valid = 4'b1010; #1;
    for (int i = 0; i < 4; i++) begin
      chk("alt_ready", 32'(in_ready), (i % 2 == 0) ? 32'b0010 : 32'b1000);
      cyc();
      chk_out("alt", (i % 2 == 0) ? 2'd1 : 2'd3, (i % 2 == 0) ? 8'h11 : 8'h13);
    end

    // Backpressure: held beat stays put even though ch3 data changes
    out_ready = 1'b0; in_data = 32'h93121110; #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready", 32'(in_ready), 32'h0);
      cyc();
      chk_out("bp", 2'd3, 8'h13);
    end
    out_ready = 1'b1; #1;
    chk("drain_ready", 32'(in_ready), 32'b0010);
    cyc();
    chk_out("drain1", 2'd1, 8'h11);
    cyc();
    chk_out("drain2", 2'd3, 8'h93);

    // Fixed select on an invalid channel: nothing granted, output empties and holds
    mode = 1'b0; sel = 2'd0; #1;
    chk("inv_ready", 32'(in_ready), 32'h0);
    cyc();
    chk("inv_valid", 32'(out_valid), 32'h0);
    chk("inv_sel",   32'(out_sel), 32'd3);
    chk("inv_data",  32'(out_data), 32'h93);
    sel = 2'd3; #1;
    chk("sel3_ready", 32'(in_ready), 32'b1000);
    cyc();
    chk_out("sel3", 2'd3, 8'h93);

`ifdef STREAM_MUX_PKT_LOCK_EN
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    mode = 1'b1; in_data = 32'h13121110; in_valid = 4'b0001; in_last = 4'hF;
    cyc();
    chk_out("lk_pre", 2'd0, 8'h10);
    in_valid = 4'b0111; in_last = 4'b1101; #1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin in_last = 4'hF; #1; end
      chk("lk_ready", 32'(in_ready), 32'b0010);
      cyc();
      chk_out("lk", 2'd1, 8'h11);
      chk("lk_last", 32'(out_last), (i == 2) ? 32'd1 : 32'd0);
    end
    #1;
    chk("lk_after_ready", 32'(in_ready), 32'b0100);
    cyc();
    chk_out("lk_after", 2'd2, 8'h12);

    // Lock onto ch1, then reset mid-packet
    in_valid = 4'b0010; in_last = 4'b1101;
    cyc();
    chk_out("lk2_b1", 2'd1, 8'h11);
    in_valid = 4'b0111; #1;
    chk("lk2_ready", 32'(in_ready), 32'b0010);
    cyc();
    rst_n = 1'b0; cyc();
    chk("lk2_rst_valid", 32'(out_valid), 32'h0);
    chk("lk2_rst_last",  32'(out_last), 32'h0);
    rst_n = 1'b1; #1;
    chk("lk2_rel_ready", 32'(in_ready), 32'b0001);
    cyc();
    chk_out("lk2_rel", 2'd0, 8'h10);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
